// File: rtl/spi_reply_scheduler.sv
// Per-frame reply scheduler between the SPI slave PHY and the channel reply FIFOs.
// It picks a round-robin data word or the status word, and decodes host frames into writes and requests.
module spi_reply_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int STATUS_EVERY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 frame_done,
    input  logic [31:0]          rx_word,
    output logic [31:0]          tx_word,
    output logic                 tx_load,
    input  logic [NUM_CH-1:0]    src_valid,
    input  logic [NUM_CH*28-1:0] src_data,
    output logic [NUM_CH-1:0]    src_ack,
    input  logic [12:0]          rx_fifo_count,
    output logic                 wr_valid,
    output logic [3:0]           wr_index,
    output logic [27:0]          wr_data,
    output logic [7:0]           abort_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY
    } state_t;

    state_t                state, state_nx;
    logic [3:0]            rr_ptr;
    logic [7:0]            data_cnt;
    logic                  cnt_req;
    logic                  force_status;
    logic [31:0]           last_status;
    logic [31:0]           tx_word_q;

    logic [2*NUM_CH-1:0]   valid_dbl, rot_dbl, oh_dbl, gnt_dbl;
    logic [NUM_CH-1:0]     rot_valid, oh_rot, grant_oh;
    logic [3:0]            grant_idx;
    logic [27:0]           grant_data;
    logic                  send_status;
    logic [26:0]           status_body;
    logic [31:0]           status_word;
    logic [31:0]           reply_word;
    logic                  loading;
    logic                  abort;
    logic [3:0]            rx_idx;

    // Round-robin: rotate valid so the channel after rr_ptr sits at bit 0,
    // isolate the lowest set bit, then rotate the one-hot back.
    always_comb begin
        valid_dbl  = {src_valid, src_valid};
        rot_dbl    = valid_dbl >> rr_ptr;
        rot_valid  = rot_dbl[NUM_CH-1:0];
        oh_rot     = rot_valid & (-rot_valid);
        oh_dbl     = {oh_rot, oh_rot};
        gnt_dbl    = oh_dbl << rr_ptr;
        grant_oh   = gnt_dbl[2*NUM_CH-1:NUM_CH];
        grant_idx  = '0;
        grant_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_oh[c]) begin
                grant_idx  = 4'(c + 1);
                grant_data = src_data[28*c +: 28];
            end
        end
    end

    always_comb begin
        status_body = {cnt_req, ~|src_valid, |rx_fifo_count, rx_fifo_count, 11'(src_valid)};
        status_word = {4'h0, (status_body == last_status[26:0]), status_body};
        send_status = ~|src_valid | cnt_req | force_status
                    | (data_cnt == 8'(STATUS_EVERY));
        reply_word  = send_status ? status_word : {grant_idx, grant_data};
    end

    always_comb begin
        state_nx = state;
        abort    = 1'b0;
        case (state)
            IDLE: if (frame_start) state_nx = LOAD;
            LOAD: state_nx = BUSY;
            BUSY: begin
                if (frame_start) begin
                    state_nx = LOAD;
                    abort    = ~frame_done;
                end else if (frame_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        loading = (state == LOAD);
        tx_load = loading;
        tx_word = loading ? reply_word : tx_word_q;
        src_ack = (loading && !send_status) ? grant_oh : '0;
        rx_idx  = rx_word[31:28];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Host decode is ordered after the LOAD clear so a request arriving in
    // the load cycle is kept for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_word_q    <= '0;
            rr_ptr       <= 4'(NUM_CH);
            data_cnt     <= '0;
            cnt_req      <= 1'b0;
            force_status <= 1'b0;
            last_status  <= '1;
            wr_valid     <= 1'b0;
            wr_index     <= '0;
            wr_data      <= '0;
            abort_cnt    <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (loading) begin
                tx_word_q <= reply_word;
                if (send_status) begin
                    last_status  <= status_word;
                    data_cnt     <= '0;
                    cnt_req      <= 1'b0;
                    force_status <= 1'b0;
                end else begin
                    rr_ptr   <= grant_idx;
                    data_cnt <= data_cnt + 8'd1;
                end
            end
            if (frame_done) begin
                if (rx_idx == 4'd0) begin
                    if (rx_word[0]) cnt_req <= 1'b1;
                    if (rx_word[1]) force_status <= 1'b1;
                end else if (rx_idx <= 4'(NUM_CH)) begin
                    wr_valid <= 1'b1;
                    wr_index <= rx_idx;
                    wr_data  <= rx_word[27:0];
                end
            end
            if (abort && abort_cnt != 8'hFF) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reply_scheduler.sv
// Randomized scoreboard bench for spi_reply_scheduler against a behavioural reply/decode model.
module tb_spi_reply_scheduler;

    localparam int NUM_CH       = 4;
    localparam int STATUS_EVERY = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 frame_start;
    logic                 frame_done;
    logic [31:0]          rx_word;
    logic [31:0]          tx_word;
    logic                 tx_load;
    logic [NUM_CH-1:0]    src_valid;
    logic [NUM_CH*28-1:0] src_data;
    logic [NUM_CH-1:0]    src_ack;
    logic [12:0]          rx_fifo_count;
    logic                 wr_valid;
    logic [3:0]           wr_index;
    logic [27:0]          wr_data;
    logic [7:0]           abort_cnt;

    spi_reply_scheduler #(.NUM_CH(NUM_CH), .STATUS_EVERY(STATUS_EVERY)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_done(frame_done),
        .rx_word(rx_word), .tx_word(tx_word), .tx_load(tx_load),
        .src_valid(src_valid), .src_data(src_data), .src_ack(src_ack),
        .rx_fifo_count(rx_fifo_count), .wr_valid(wr_valid), .wr_index(wr_index),
        .wr_data(wr_data), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                cyc;
        logic [31:0]       word;
        logic [NUM_CH-1:0] ack;
    } tx_exp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [27:0] data;
    } wr_exp_t;

    tx_exp_t txq[$];
    wr_exp_t wrq[$];
    tx_exp_t mon_e;
    wr_exp_t mon_w;

    // reference model state
    int          m_ptr;
    int          m_cnt;
    bit          m_req;
    bit          m_force;
    logic [31:0] m_last;
    int          m_abort;

    function void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function void model_reset();
        m_ptr   = NUM_CH;
        m_cnt   = 0;
        m_req   = 0;
        m_force = 0;
        m_last  = 32'hFFFF_FFFF;
        m_abort = 0;
    endfunction

    function void model_load(int at);
        tx_exp_t     e;
        logic [31:0] w;
        int          ch;
        e.cyc = at;
        e.ack = '0;
        if (src_valid == '0 || m_req || m_force || m_cnt == STATUS_EVERY) begin
            w        = '0;
            w[26]    = m_req;
            w[25]    = (src_valid == '0);
            w[24]    = (rx_fifo_count != 0);
            w[23:11] = rx_fifo_count;
            w[10:0]  = 11'(src_valid);
            w[27]    = (w[26:0] == m_last[26:0]);
            m_last   = w;
            m_cnt    = 0;
            m_req    = 0;
            m_force  = 0;
        end else begin
            ch = 0;
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_ptr + k - 1) % NUM_CH + 1;
                if (ch == 0 && src_valid[c-1]) ch = c;
            end
            w = {4'(ch), src_data[28*(ch-1) +: 28]};
            e.ack[ch-1] = 1'b1;
            m_ptr = ch;
            m_cnt++;
        end
        e.word = w;
        txq.push_back(e);
    endfunction

    function void model_decode(logic [31:0] host, int at);
        wr_exp_t e;
        if (host[31:28] == 4'd0) begin
            if (host[0]) m_req = 1;
            if (host[1]) m_force = 1;
        end else if (host[31:28] <= NUM_CH) begin
            e.cyc  = at;
            e.idx  = host[31:28];
            e.data = host[27:0];
            wrq.push_back(e);
        end
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_load) begin
                if (txq.size() == 0) begin
                    check("unexpected_tx_load", 32'd1, 32'd0);
                end else begin
                    mon_e = txq.pop_front();
                    check("tx_cycle", cyc, mon_e.cyc);
                    check("tx_word", tx_word, mon_e.word);
                    check("src_ack", 32'(src_ack), 32'(mon_e.ack));
                end
            end else if (src_ack != '0) begin
                check("stray_src_ack", 32'(src_ack), 32'd0);
            end
            if (wr_valid) begin
                if (wrq.size() == 0) begin
                    check("unexpected_wr_valid", 32'd1, 32'd0);
                end else begin
                    mon_w = wrq.pop_front();
                    check("wr_cycle", cyc, mon_w.cyc);
                    check("wr_index", 32'(wr_index), 32'(mon_w.idx));
                    check("wr_data", 32'(wr_data), 32'(mon_w.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_src();
        for (int c = 0; c < NUM_CH; c++) src_data[28*c +: 28] = 28'($urandom);
    endtask

    task automatic t_start();
        model_load(cyc + 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic t_abort();
        if (m_abort < 255) m_abort++;
        t_start();
    endtask

    task automatic t_done(input logic [31:0] host);
        model_decode(host, cyc + 1);
        rx_word    = host;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
    endtask

    task automatic t_done_start(input logic [31:0] host);
        model_decode(host, cyc + 1);
        model_load(cyc + 1);
        rx_word     = host;
        frame_done  = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_done  = 1'b0;
        frame_start = 1'b0;
        tick();
    endtask

    task automatic frame(input logic [31:0] host, input int busy);
        t_start();
        repeat (busy) tick();
        t_done(host);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_tx_word"}, tx_word, 32'd0);
        check({tag, "_tx_load"}, 32'(tx_load), 32'd0);
        check({tag, "_src_ack"}, 32'(src_ack), 32'd0);
        check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        check({tag, "_wr_index"}, 32'(wr_index), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_abort_cnt"}, 32'(abort_cnt), 32'd0);
    endtask

    initial begin
        bit started;
        rst           = 1'b1;
        frame_start   = 1'b0;
        frame_done    = 1'b0;
        rx_word       = '0;
        src_valid     = '0;
        src_data      = '0;
        rx_fifo_count = '0;
        model_reset();
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // empty sources: status twice, second one with shadow
        rx_fifo_count = 13'd5;
        frame(32'h0, 2);
        frame(32'h0, 2);

        // all channels valid: 1,2,3,4,1,2,3,4 then status
        src_valid = '1;
        for (int i = 0; i < 9; i++) begin
            rand_src();
            frame({4'($urandom_range(1, NUM_CH)), 28'($urandom)}, 1);
        end

        // count request with only channel 2 valid
        src_valid = 4'b0010;
        frame(32'h0000_0001, 1);
        frame(32'h0, 1);
        frame(32'h0, 1);

        // write decode and out-of-range index
        src_valid = '1;
        frame(32'h3ABC_DEF0, 1);
        frame(32'hF000_0001, 1);
        frame(32'h0, 1);

        // force status
        frame(32'h0000_0002, 1);
        frame(32'h0, 1);

        // done and start in the same cycle
        t_start();
        tick();
        t_done_start(32'h0000_0001);
        t_done(32'h0);

        // aborted frames
        rand_src();
        t_start();
        repeat (3) t_abort();
        check("abort_cnt_3", 32'(abort_cnt), 32'd3);
        repeat (300) t_abort();
        check("abort_cnt_sat", 32'(abort_cnt), 32'd255);
        check("abort_cnt_model", 32'(abort_cnt), 32'(m_abort));
        t_done(32'h0);

        // reset in BUSY
        src_valid = 4'b0001;
        t_start();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        model_reset();
        tick();
        src_valid = '1;
        rand_src();
        frame(32'h0, 1);

        // random traffic
        started = 0;
        for (int i = 0; i < 80; i++) begin
            if (!started) begin
                src_valid     = NUM_CH'($urandom);
                rx_fifo_count = 13'($urandom_range(0, 8191));
                rand_src();
                t_start();
            end
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) begin
                src_valid     = NUM_CH'($urandom);
                rx_fifo_count = 13'($urandom_range(0, 8191));
                rand_src();
                t_done_start({4'($urandom_range(0, 15)), 28'($urandom)});
                started = 1;
            end else begin
                t_done({4'($urandom_range(0, 15)), 28'($urandom)});
                started = 0;
            end
        end
        if (started) t_done(32'h0);

        repeat (5) tick();
        check("txq_drained", 32'(txq.size()), 32'd0);
        check("wrq_drained", 32'(wrq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
